wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the two writeback/wakeup ports (writeback0/1) between NUM_REQ execution units (ALU0, ALU1, MULDIV, LSU).
- Each requester gets a 1-entry holding slot. Up to two slots are granted per cycle with a rotating round-robin pointer.
- Winners are registered onto the writeback ports, which feed issue-queue wakeup, ROB completion and regfile write.
- Redirect flush kills held or in-flight results younger than the flushing instruction.

Parameters:
- NUM_REQ, 4, number of execution-unit requesters (2..8).
- PREG_W, 6, physical register index width.
- ROB_SIZE_LOG, 6, ROB index width; an age flag bit is carried separately.
- DATA_W, 64, result data width.

Ports:
- clock  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a result.
- req_ready  out  NUM_REQ  slot i can accept this cycle.
- req_need_to_wb  in  NUM_REQ  result writes a preg.
- req_prd  in  NUM_REQ*PREG_W  destination preg, requester i at bits [i*PREG_W +: PREG_W].
- req_data  in  NUM_REQ*DATA_W  result data.
- req_robidx_flag  in  NUM_REQ  ROB age flag.
- req_robidx  in  NUM_REQ*ROB_SIZE_LOG  ROB index.
- flush_valid  in  1  redirect flush.
- flush_robidx_flag  in  1  flushing instruction's ROB flag.
- flush_robidx  in  ROB_SIZE_LOG  flushing instruction's ROB index.
- writeback{0,1}_valid  out  1  port carries a result.
- writeback{0,1}_need_to_wb  out  1  port result writes a preg.
- writeback{0,1}_prd  out  PREG_W  destination preg.
- writeback{0,1}_data  out  DATA_W  result data.
- writeback{0,1}_robidx_flag  out  1  ROB age flag.
- writeback{0,1}_robidx  out  ROB_SIZE_LOG  ROB index.

Behaviour:
- Reset (async):
  - all slot_valid = 0; rr_ptr = 0.
  - writeback{0,1}_valid = 0; all other writeback outputs = 0.
  - req_ready is then all-ones.
- Slot accept:
  - req_ready[i] = ~slot_valid[i] | grant[i].
  - req_valid[i] & req_ready[i] loads slot i next cycle.
  - Grant and reload of the same slot in one cycle is legal, giving back-to-back throughput.
- Younger test, for flag F / index X against slot flag f / index x: young = (F ^ f) ^ (X < x).
  - Strictly younger only; the flushing instruction itself survives.
- Flush, while flush_valid is high:
  - A slot with young=1 is not eligible for grant and is cleared next cycle.
  - An incoming request with young=1 is accepted (ready per rule above) but not stored.
- Arbitration, combinational, on eligible slots = slot_valid & ~young:
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - First hit → port0, second hit → port1; further hits wait.
- rr_ptr update:
  - Next value is (index of last grant + 1) mod NUM_REQ.
  - It is unchanged if there were no grants.
  - It is not reset by flush.
- Output register:
  - Granted slot contents register onto port 0/1 next cycle.
  - writebackN_valid = 1 only in the cycle after its grant; otherwise 0.
  - Data fields hold their last value when valid = 0.
- Latency: req accepted at cycle t → slot at t+1 → granted at t+1 → writeback valid at t+2 (minimum).
- Flush vs in-flight output:
  - A result already in the output register when flush rises is still driven that cycle.
  - Consumers discard it via their own flush compare.
- Fairness: an eligible slot is granted within ceil(NUM_REQ/2) arbitration cycles.
- Ordering: only one grant per slot per cycle, so port0 and port1 never carry the same slot.
- Single port used: when only one slot is eligible, port0 carries it and writeback1_valid = 0.
- need_to_wb=0 results still take a port; ROB completion needs them.

Decomposition:
- Shared package (backend defines):
  - PREG_RANGE and ROB_SIZE_LOG constants.
  - A writeback-bundle struct {valid, need_to_wb, prd, data, robidx_flag, robidx}.
  - An age-compare function is_younger(flag, idx, flag, idx), also reusable by issue-queue flush.
- Sub-module rr_pick2: combinational, inputs eligible[NUM_REQ] and rr_ptr; outputs gnt0_oh, gnt1_oh, gnt0_vld, gnt1_vld, last_idx.

Test Plan:
- Reset, then idle → all req_ready = 1, both writeback valid = 0 for 10 cycles.
- Single requester: req0 prd=5, robidx=3 at cycle t → writeback0_valid=1, prd=5 at t+2; writeback1_valid=0.
- All 4 requesters valid every cycle, rr_ptr=0:
  - Grants are {0,1}, {2,3}, {0,1} …
  - Each requester's ready toggles so it is accepted every 2nd cycle.
  - No slot waits more than 2 cycles.
- Flush:
  - Setup: slots hold robidx 2, 7, 9 (flag 0); flush_robidx=7, flag 0.
  - Required: slot 7 survives; slot 9 is cleared and never appears on a port; slot 2 is granted.
- Wrap age: slot flag=1, robidx=1, with flush flag=0, robidx=60 → slot treated as younger and dropped.
- Back-to-back: req2 valid continuously with rr_ptr=2 → req2 granted and reloaded every cycle; writeback0 carries it each cycle; req_ready[2] stays 1.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: backend-wide writeback bundle type, widths and ROB age compare.
package wb_port_arbiter_pkg;
  localparam int PREG_RANGE = 64;
  localparam int PREG_IDX_W = $clog2(PREG_RANGE);
  localparam int ROB_SIZE_LOG = 6;
  localparam int XLEN = 64;
  typedef struct packed {
    logic                    valid;
    logic                    need_to_wb;
    logic [PREG_IDX_W-1:0]   prd;
    logic [XLEN-1:0]         data;
    logic                    robidx_flag;
    logic [ROB_SIZE_LOG-1:0] robidx;
  } wb_bundle_t;
  // True when {flag, idx} is strictly younger than the reference {ref_flag, ref_idx}.
  function automatic logic is_younger(input logic ref_flag, input logic [ROB_SIZE_LOG-1:0] ref_idx,
                                      input logic flag, input logic [ROB_SIZE_LOG-1:0] idx);
    return (ref_flag ^ flag) ^ (ref_idx < idx);
  endfunction
endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// wb_port_arbiter_rr_pick2: picks the first two eligible requesters scanning round-robin from rr_ptr.
module wb_port_arbiter_rr_pick2 #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt0_oh,
  output logic [NUM_REQ-1:0] gnt1_oh,
  output logic               gnt0_vld,
  output logic               gnt1_vld,
  output logic [PTR_W-1:0]   gnt0_idx,
  output logic [PTR_W-1:0]   gnt1_idx,
  output logic [PTR_W-1:0]   last_idx
);
  logic [PTR_W-1:0] idx;
  always_comb begin
    gnt0_oh = '0;
    gnt1_oh = '0;
    gnt0_vld = 1'b0;
    gnt1_vld = 1'b0;
    gnt0_idx = '0;
    gnt1_idx = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (eligible[idx] && !gnt0_vld) begin
        gnt0_vld = 1'b1;
        gnt0_oh[idx] = 1'b1;
        gnt0_idx = idx;
      end else if (eligible[idx] && !gnt1_vld) begin
        gnt1_vld = 1'b1;
        gnt1_oh[idx] = 1'b1;
        gnt1_idx = idx;
      end
    end
    last_idx = gnt1_vld ? gnt1_idx : gnt0_idx;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares two writeback ports among NUM_REQ execution units through
// one holding slot per unit, round-robin picking two per cycle, with redirect flush.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PREG_W = PREG_IDX_W,
  parameter int ROB_SIZE_LOG = wb_port_arbiter_pkg::ROB_SIZE_LOG,
  parameter int DATA_W = XLEN
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_need_to_wb,
  input  logic [NUM_REQ*PREG_W-1:0]       req_prd,
  input  logic [NUM_REQ*DATA_W-1:0]       req_data,
  input  logic [NUM_REQ-1:0]              req_robidx_flag,
  input  logic [NUM_REQ*ROB_SIZE_LOG-1:0] req_robidx,
  input  logic                            flush_valid,
  input  logic                            flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0]         flush_robidx,
  output logic                            writeback0_valid,
  output logic                            writeback0_need_to_wb,
  output logic [PREG_W-1:0]               writeback0_prd,
  output logic [DATA_W-1:0]               writeback0_data,
  output logic                            writeback0_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0]         writeback0_robidx,
  output logic                            writeback1_valid,
  output logic                            writeback1_need_to_wb,
  output logic [PREG_W-1:0]               writeback1_prd,
  output logic [DATA_W-1:0]               writeback1_data,
  output logic                            writeback1_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0]         writeback1_robidx
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                   slot_valid, slot_ntw, slot_flag;
  logic [NUM_REQ-1:0][PREG_W-1:0]       slot_prd;
  logic [NUM_REQ-1:0][DATA_W-1:0]       slot_data;
  logic [NUM_REQ-1:0][ROB_SIZE_LOG-1:0] slot_idx;
  logic [NUM_REQ-1:0] young_slot, young_req, eligible, grant, load, gnt0_oh, gnt1_oh;
  logic               gnt0_vld, gnt1_vld;
  logic [PTR_W-1:0]   rr_ptr, gnt0_idx, gnt1_idx, last_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
    assign young_slot[i] = flush_valid & is_younger(flush_robidx_flag, flush_robidx, slot_flag[i], slot_idx[i]);
    assign young_req[i] = flush_valid & is_younger(flush_robidx_flag, flush_robidx, req_robidx_flag[i],
                                                   req_robidx[i*ROB_SIZE_LOG +: ROB_SIZE_LOG]);
  end

  assign eligible = slot_valid & ~young_slot;
  assign grant = gnt0_oh | gnt1_oh;
  assign req_ready = ~slot_valid | grant;
  // Flushed-young requests are handshaken but dropped on the floor.
  assign load = req_valid & req_ready & ~young_req;

  wb_port_arbiter_rr_pick2 #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .eligible(eligible),
    .rr_ptr(rr_ptr),
    .gnt0_oh(gnt0_oh),
    .gnt1_oh(gnt1_oh),
    .gnt0_vld(gnt0_vld),
    .gnt1_vld(gnt1_vld),
    .gnt0_idx(gnt0_idx),
    .gnt1_idx(gnt1_idx),
    .last_idx(last_idx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
      rr_ptr <= '0;
    end else begin
      slot_valid <= load | (slot_valid & ~grant & ~young_slot);
      if (gnt0_vld) rr_ptr <= (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (load[i]) begin
        slot_ntw[i] <= req_need_to_wb[i];
        slot_prd[i] <= req_prd[i*PREG_W +: PREG_W];
        slot_data[i] <= req_data[i*DATA_W +: DATA_W];
        slot_flag[i] <= req_robidx_flag[i];
        slot_idx[i] <= req_robidx[i*ROB_SIZE_LOG +: ROB_SIZE_LOG];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      writeback0_valid <= 1'b0;
      writeback0_need_to_wb <= 1'b0;
      writeback0_prd <= '0;
      writeback0_data <= '0;
      writeback0_robidx_flag <= 1'b0;
      writeback0_robidx <= '0;
      writeback1_valid <= 1'b0;
      writeback1_need_to_wb <= 1'b0;
      writeback1_prd <= '0;
      writeback1_data <= '0;
      writeback1_robidx_flag <= 1'b0;
      writeback1_robidx <= '0;
    end else begin
      writeback0_valid <= gnt0_vld;
      writeback1_valid <= gnt1_vld;
      if (gnt0_vld) begin
        writeback0_need_to_wb <= slot_ntw[gnt0_idx];
        writeback0_prd <= slot_prd[gnt0_idx];
        writeback0_data <= slot_data[gnt0_idx];
        writeback0_robidx_flag <= slot_flag[gnt0_idx];
        writeback0_robidx <= slot_idx[gnt0_idx];
      end
      if (gnt1_vld) begin
        writeback1_need_to_wb <= slot_ntw[gnt1_idx];
        writeback1_prd <= slot_prd[gnt1_idx];
        writeback1_data <= slot_data[gnt1_idx];
        writeback1_robidx_flag <= slot_flag[gnt1_idx];
        writeback1_robidx <= slot_idx[gnt1_idx];
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: randomized and directed stimulus against a queue-based reference
// model; a negedge monitor pops expected port results and compares.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;
  localparam int N = 4;
  localparam int PW = PREG_IDX_W;
  localparam int RW = ROB_SIZE_LOG;
  localparam int DW = XLEN;
  localparam int AGE_SPAN = 2 ** (RW + 1);

  typedef struct {
    int         cyc;
    wb_bundle_t b;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_need_to_wb = '0, req_robidx_flag = '0;
  logic [N*PW-1:0] req_prd = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*RW-1:0] req_robidx = '0;
  logic flush_valid = 1'b0, flush_robidx_flag = 1'b0;
  logic [RW-1:0] flush_robidx = '0;
  logic wb0_valid, wb0_ntw, wb0_flag, wb1_valid, wb1_ntw, wb1_flag;
  logic [PW-1:0] wb0_prd, wb1_prd;
  logic [DW-1:0] wb0_data, wb1_data;
  logic [RW-1:0] wb0_idx, wb1_idx;

  wb_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_need_to_wb(req_need_to_wb),
    .req_prd(req_prd), .req_data(req_data), .req_robidx_flag(req_robidx_flag), .req_robidx(req_robidx),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx),
    .writeback0_valid(wb0_valid), .writeback0_need_to_wb(wb0_ntw), .writeback0_prd(wb0_prd),
    .writeback0_data(wb0_data), .writeback0_robidx_flag(wb0_flag), .writeback0_robidx(wb0_idx),
    .writeback1_valid(wb1_valid), .writeback1_need_to_wb(wb1_ntw), .writeback1_prd(wb1_prd),
    .writeback1_data(wb1_data), .writeback1_robidx_flag(wb1_flag), .writeback1_robidx(wb1_idx)
  );

  initial forever #5 clock = ~clock;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t exp0[$], exp1[$];

  bit         s_valid[N], s_ntw[N], s_flag[N];
  logic [PW-1:0] s_prd[N];
  logic [DW-1:0] s_data[N];
  logic [RW-1:0] s_idx[N];
  bit         f_valid, f_flag;
  logic [RW-1:0] f_idx;

  bit         mv[N];
  wb_bundle_t mb[N];
  int         rr = 0;
  int         wait_c[N];

  always @(posedge clock) cyc++;

  // Age as distance around the doubled ROB ring: strictly younger is 1..ROB entries ahead.
  function automatic bit model_younger(bit ff, int fi, bit sf, int si);
    int d;
    d = ((int'(sf) * (AGE_SPAN / 2) + si) - (int'(ff) * (AGE_SPAN / 2) + fi) + AGE_SPAN) % AGE_SPAN;
    return d >= 1 && d <= AGE_SPAN / 2;
  endfunction

  task automatic check_port(input int p, input wb_bundle_t a);
    exp_t e;
    bit have;
    have = 1'b0;
    if (p == 0 && exp0.size() > 0 && exp0[0].cyc == cyc) begin have = 1'b1; e = exp0.pop_front(); end
    if (p == 1 && exp1.size() > 0 && exp1[0].cyc == cyc) begin have = 1'b1; e = exp1.pop_front(); end
    vectors++;
    if (have && a !== e.b) begin
      miscompares++;
      $display("FAIL wb%0d_result cyc %0d: got %h, required %h", p, cyc, a, e.b);
    end else if (!have && a.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wb%0d_idle cyc %0d: got valid=%b, required valid=0", p, cyc, a.valid);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      check_port(0, {wb0_valid, wb0_ntw, wb0_prd, wb0_data, wb0_flag, wb0_idx});
      check_port(1, {wb1_valid, wb1_ntw, wb1_prd, wb1_data, wb1_flag, wb1_idx});
    end
  end

  task automatic clear_stim();
    for (int i = 0; i < N; i++) s_valid[i] = 1'b0;
    f_valid = 1'b0;
  endtask

  task automatic set_req(input int i, input bit flag, input int idx, input int prd);
    s_valid[i] = 1'b1;
    s_ntw[i] = 1'b1;
    s_flag[i] = flag;
    s_idx[i] = RW'(idx);
    s_prd[i] = PW'(prd);
    s_data[i] = {$urandom, $urandom};
  endtask

  task automatic rand_req(input int i);
    s_valid[i] = 1'b1;
    s_ntw[i] = 1'($urandom);
    s_flag[i] = 1'($urandom);
    s_idx[i] = RW'($urandom);
    s_prd[i] = PW'($urandom);
    s_data[i] = {$urandom, $urandom};
  endtask

  task automatic step();
    int cand[$];
    bit ys[N], gr[N], yr;
    logic [N-1:0] er;
    int g0, g1;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = s_valid[i];
      req_need_to_wb[i] = s_ntw[i];
      req_robidx_flag[i] = s_flag[i];
      req_prd[i*PW +: PW] = s_prd[i];
      req_data[i*DW +: DW] = s_data[i];
      req_robidx[i*RW +: RW] = s_idx[i];
    end
    flush_valid = f_valid;
    flush_robidx_flag = f_flag;
    flush_robidx = f_idx;
    #1;
    for (int i = 0; i < N; i++)
      ys[i] = mv[i] && f_valid && model_younger(f_flag, int'(f_idx), mb[i].robidx_flag, int'(mb[i].robidx));
    for (int k = 0; k < N; k++)
      if (mv[(rr + k) % N] && !ys[(rr + k) % N]) cand.push_back((rr + k) % N);
    g0 = cand.size() > 0 ? cand[0] : -1;
    g1 = cand.size() > 1 ? cand[1] : -1;
    for (int i = 0; i < N; i++) begin
      gr[i] = (i == g0) || (i == g1);
      er[i] = !mv[i] || gr[i];
    end
    vectors++;
    if (req_ready !== er) begin
      miscompares++;
      $display("FAIL req_ready cyc %0d: got %b, required %b", cyc, req_ready, er);
    end
    if (g0 >= 0) begin e.cyc = cyc + 1; e.b = mb[g0]; exp0.push_back(e); end
    if (g1 >= 0) begin e.cyc = cyc + 1; e.b = mb[g1]; exp1.push_back(e); end
    for (int i = 0; i < N; i++) begin
      if (mv[i] && !ys[i] && !gr[i]) begin
        wait_c[i]++;
        vectors++;
        if (wait_c[i] > (N + 1) / 2 - 1) begin
          miscompares++;
          $display("FAIL fairness slot%0d cyc %0d: waited %0d, required <= %0d", i, cyc, wait_c[i], (N + 1) / 2 - 1);
        end
      end else wait_c[i] = 0;
    end
    if (g1 >= 0) rr = (g1 + 1) % N;
    else if (g0 >= 0) rr = (g0 + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (gr[i] || ys[i]) mv[i] = 1'b0;
      yr = f_valid && model_younger(f_flag, int'(f_idx), s_flag[i], int'(s_idx[i]));
      if (s_valid[i] && er[i] && !yr) begin
        mv[i] = 1'b1;
        mb[i] = {1'b1, s_ntw[i], s_prd[i], s_data[i], s_flag[i], s_idx[i]};
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    clear_stim();
    repeat (n) step();
  endtask

  initial begin
    clear_stim();
    for (int i = 0; i < N; i++) begin mv[i] = 1'b0; wait_c[i] = 0; end
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({wb0_valid, wb0_ntw, wb0_prd, wb0_data, wb0_flag, wb0_idx, wb1_valid, wb1_ntw, wb1_prd, wb1_data, wb1_flag, wb1_idx} !== '0
        || req_ready !== '1) begin
      miscompares++;
      $display("FAIL reset_state: got wb0_valid=%b wb1_valid=%b ready=%b, required all-zero outputs and ready=1111",
               wb0_valid, wb1_valid, req_ready);
    end
    reset_n = 1'b1;
    idle(10);
    // single requester: req0 prd 5 robidx 3
    set_req(0, 1'b0, 3, 5);
    step();
    idle(3);
    // steer rr_ptr back to 0, then all four valid every cycle
    set_req(3, 1'b0, 4, 9);
    step();
    idle(3);
    repeat (8) begin
      for (int i = 0; i < N; i++) rand_req(i);
      step();
    end
    idle(4);
    // flush: slots hold robidx 2, 7, 9; flush at 7
    set_req(0, 1'b0, 2, 10);
    set_req(1, 1'b0, 7, 11);
    set_req(2, 1'b0, 9, 12);
    step();
    clear_stim();
    f_valid = 1'b1; f_flag = 1'b0; f_idx = RW'(7);
    step();
    idle(3);
    // wrapped age: slot {1,1} is younger than flush {0,60}
    set_req(1, 1'b1, 1, 20);
    step();
    clear_stim();
    f_valid = 1'b1; f_flag = 1'b0; f_idx = RW'(60);
    step();
    idle(3);
    // back-to-back on requester 2 with rr_ptr at 2
    set_req(1, 1'b0, 5, 21);
    step();
    idle(2);
    repeat (8) begin
      clear_stim();
      rand_req(2);
      step();
    end
    idle(3);
    repeat (600) begin
      clear_stim();
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) < 6) rand_req(i);
      f_valid = ($urandom_range(0, 9) == 0);
      f_flag = 1'($urandom);
      f_idx = RW'($urandom);
      step();
    end
    idle(5);
    vectors++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d undelivered results, required 0/0", exp0.size(), exp1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
